// File: rtl/traffic_phase_fsm_if.sv
// Signal bundle between the tick source / request inputs and the phase sequencer.
// The sequencer sits on the slave side; the stimulus or system side on the master side.
interface traffic_phase_fsm_if;
  logic       enable_1Hz;
  logic       side_sensor;
  logic       ped_button;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] phase;
  logic [7:0] phase_timer;

  modport master (
    output enable_1Hz, side_sensor, ped_button,
    input  main_light, side_light, walk, phase, phase_timer
  );

  modport slave (
    input  enable_1Hz, side_sensor, ped_button,
    output main_light, side_light, walk, phase, phase_timer
  );
endinterface

// File: rtl/traffic_phase_fsm.sv
// Two-road intersection phase sequencer counting phase durations in divider ticks.
// Optional pedestrian walk phase enabled by defining TRAFFIC_PED_REQUEST_EN.
module traffic_phase_fsm #(
  parameter int unsigned GREEN_MAIN = 4,
  parameter int unsigned GREEN_SIDE = 3,
  parameter int unsigned YELLOW     = 2,
  parameter int unsigned ALL_RED    = 1,
  parameter int unsigned WALK       = 2
) (
  input logic            clk,
  input logic            global_reset,
  traffic_phase_fsm_if.slave bus
);

  localparam logic [2:0] MAIN_G = 3'd0;
  localparam logic [2:0] MAIN_Y = 3'd1;
  localparam logic [2:0] RED_A  = 3'd2;
  localparam logic [2:0] SIDE_G = 3'd3;
  localparam logic [2:0] SIDE_Y = 3'd4;
  localparam logic [2:0] RED_B  = 3'd5;
  localparam logic [2:0] WALK_S = 3'd6;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       side_req_q, side_req_d;
  logic       ped_req;
  logic [7:0] dur;
  logic       last;
  logic       expire;

  always_comb begin
    dur = 8'(GREEN_MAIN);
    case (state_q)
      MAIN_G:  dur = 8'(GREEN_MAIN);
      MAIN_Y:  dur = 8'(YELLOW);
      RED_A:   dur = 8'(ALL_RED);
      SIDE_G:  dur = 8'(GREEN_SIDE);
      SIDE_Y:  dur = 8'(YELLOW);
      RED_B:   dur = 8'(ALL_RED);
      WALK_S:  dur = 8'(WALK);
      default: dur = 8'(GREEN_MAIN);
    endcase
  end

  assign last   = (timer_q == (dur - 8'd1));
  assign expire = bus.enable_1Hz && last;

  always_comb begin
    state_d = state_q;
    if (expire) begin
      case (state_q)
        MAIN_G: if (side_req_q || ped_req) state_d = MAIN_Y;
        MAIN_Y: state_d = RED_A;
`ifdef TRAFFIC_PED_REQUEST_EN
        RED_A:  state_d = side_req_q ? SIDE_G : WALK_S;
`else
        RED_A:  state_d = SIDE_G;
`endif
        SIDE_G: state_d = SIDE_Y;
        SIDE_Y: state_d = RED_B;
        RED_B:  state_d = ped_req ? WALK_S : MAIN_G;
        default: state_d = MAIN_G;
      endcase
    end
  end

  // A non-expiring MAIN_G holds its timer at D-1 until a request arrives.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = 8'd0;
    end else if (bus.enable_1Hz && !last) begin
      timer_d = timer_q + 8'd1;
    end
  end

  // Clear on entry to SIDE_G takes priority over a same-cycle set.
  always_comb begin
    side_req_d = side_req_q;
    if (state_d == SIDE_G && state_q != SIDE_G) begin
      side_req_d = 1'b0;
    end else if (bus.side_sensor && state_q != SIDE_G && state_q != SIDE_Y) begin
      side_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge global_reset) begin
    if (!global_reset) begin
      state_q    <= MAIN_G;
      timer_q    <= 8'd0;
      side_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      side_req_q <= side_req_d;
    end
  end

`ifdef TRAFFIC_PED_REQUEST_EN
  logic ped_req_q, ped_req_d;

  always_comb begin
    ped_req_d = ped_req_q;
    if (state_d == WALK_S && state_q != WALK_S) begin
      ped_req_d = 1'b0;
    end else if (bus.ped_button && state_q != WALK_S) begin
      ped_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge global_reset) begin
    if (!global_reset) begin
      ped_req_q <= 1'b0;
    end else begin
      ped_req_q <= ped_req_d;
    end
  end

  assign ped_req  = ped_req_q;
  assign bus.walk = (state_q == WALK_S);
`else
  logic unused_ped_button;
  assign unused_ped_button = bus.ped_button;
  assign ped_req           = 1'b0;
  assign bus.walk          = 1'b0;
`endif

  // Lamps decode straight from the state register, so no input reaches an output.
  always_comb begin
    bus.main_light = LAMP_R;
    bus.side_light = LAMP_R;
    case (state_q)
      MAIN_G: bus.main_light = LAMP_G;
      MAIN_Y: bus.main_light = LAMP_Y;
      SIDE_G: bus.side_light = LAMP_G;
      SIDE_Y: bus.side_light = LAMP_Y;
      default: begin
        bus.main_light = LAMP_R;
        bus.side_light = LAMP_R;
      end
    endcase
  end

  assign bus.phase       = state_q;
  assign bus.phase_timer = timer_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed bench for traffic_phase_fsm: phase sequences, request latching, async reset
// and per-cycle lamp invariants.
module tb_traffic_phase_fsm;
  logic clk;
  logic global_reset;
  int   errors;
  int   checks;

  traffic_phase_fsm_if bus ();

  traffic_phase_fsm #(
    .GREEN_MAIN(4),
    .GREEN_SIDE(3),
    .YELLOW    (2),
    .ALL_RED   (1),
    .WALK      (2)
  ) dut (
    .clk         (clk),
    .global_reset(global_reset),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_main(input int ph);
    case (ph)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input int ph);
    case (ph)
      3:       return 3'b001;
      4:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Called at a falling edge; spans one rising edge and returns at the next falling edge.
  task automatic step(input logic en, input logic ss, input logic pb);
    bus.enable_1Hz  = en;
    bus.side_sensor = ss;
    bus.ped_button  = pb;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    global_reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    check("rst_phase", bus.phase, 0);
    check("rst_timer", bus.phase_timer, 0);
    check("rst_main", bus.main_light, 3'b001);
    check("rst_side", bus.side_light, 3'b100);
    check("rst_walk", bus.walk, 0);
    global_reset = 1'b1;
  endtask

  task automatic check_state(input string tag, input int ph, input int tm);
    check({tag, "_ph"}, bus.phase, ph);
    check({tag, "_tm"}, bus.phase_timer, tm);
    check({tag, "_main"}, bus.main_light, exp_main(ph));
    check({tag, "_side"}, bus.side_light, exp_side(ph));
    check({tag, "_walk"}, bus.walk, (ph == 6) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    check("inv_main_onehot", $onehot(bus.main_light), 1);
    check("inv_side_onehot", $onehot(bus.side_light), 1);
    check("inv_one_red", bus.main_light[2] | bus.side_light[2], 1);
  end

  int side_ph[13] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
  int side_tm[13] = '{1, 2, 3, 0, 1, 0, 0, 1, 2, 0, 1, 0, 0};
`ifdef TRAFFIC_PED_REQUEST_EN
  int ped_ph[9] = '{0, 0, 0, 1, 1, 2, 6, 6, 0};
  int ped_tm[9] = '{1, 2, 3, 0, 1, 0, 0, 1, 0};
`else
  int ped_ph[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  int ped_tm[9] = '{1, 2, 3, 3, 3, 3, 3, 3, 3};
`endif

  initial begin
    errors          = 0;
    checks          = 0;
    global_reset    = 1'b0;
    bus.enable_1Hz  = 1'b0;
    bus.side_sensor = 1'b0;
    bus.ped_button  = 1'b0;
    @(negedge clk);

    // Idle: no requests, MAIN_G timer saturates at D-1.
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0);
    check_state("idle", 0, 3);

    // Side request; sensor also raised on the SIDE_G-entry edge and during SIDE_G/SIDE_Y.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 13; k++) begin
      step(1'b1, (k >= 6 && k <= 11), 1'b0);
      check_state($sformatf("side%0d", k), side_ph[k], side_tm[k]);
    end
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
    check("side_noreq_ph", bus.phase, 0);

    // Pedestrian request only.
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b0, 1'b0);
      check_state($sformatf("ped%0d", k), ped_ph[k], ped_tm[k]);
    end

    // Sensor held: side road served again after the MAIN_G minimum.
    do_reset();
    for (int k = 0; k < 13; k++) step(1'b1, 1'b1, 1'b0);
    check_state("hold13", 0, 0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0);
    check_state("hold17", 1, 0);

    // Asynchronous reset in the middle of SIDE_G.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0);
    check_state("pre_arst", 3, 1);
    #2 global_reset = 1'b0;
    #1;
    check_state("arst", 0, 0);
    @(negedge clk);
    global_reset = 1'b1;
    check_state("arst_rel", 0, 0);
    step(1'b1, 1'b0, 1'b0);
    check_state("arst_tick", 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/traffic_phase_fsm.md
# traffic_phase_fsm

Phase sequencer for a two-road intersection with main and side roads. It consumes the one-cycle `enable_1Hz` strobe from the clock divider and counts phase durations in those ticks. It steps the main/side signal heads through green, yellow and all-red phases, optionally with a pedestrian walk phase. Its light outputs drive the lamp/display stage directly.

## Interface
- `GREEN_MAIN`, 4: minimum main-road green duration, in ticks (1..255)
- `GREEN_SIDE`, 3: side-road green duration, in ticks (1..255)
- `YELLOW`, 2: yellow duration, in ticks, for either road (1..255)
- `ALL_RED`, 1: all-red clearance duration, in ticks (1..255)
- `WALK`, 2: pedestrian walk duration, in ticks (1..255)
- `clk`  in  1  system clock; all logic on its rising edge
- `global_reset`  in  1  asynchronous, active-low reset (0 = reset)
- `enable_1Hz`  in  1  one-cycle tick strobe from the divider
- `side_sensor`  in  1  level input: vehicle waiting on the side road
- `ped_button`  in  1  level/pulse input: pedestrian request
- `main_light`  out  3  main-road head, one-hot {R,Y,G} = bits [2:0]
- `side_light`  out  3  side-road head, one-hot {R,Y,G}
- `walk`  out  1  pedestrian walk lamp
- `phase`  out  3  current state encoding, for debug and testbench
- `phase_timer`  out  8  ticks elapsed in the current phase

## Operation
- States and encodings: MAIN_G=0, MAIN_Y=1, RED_A=2, SIDE_G=3, SIDE_Y=4, RED_B=5, WALK_S=6.
- Each phase has a duration D taken from its parameter. RED_A and RED_B both use ALL_RED.
- `phase_timer` is 0 on entry to a phase. It increments on each tick while it is below D-1.
- A phase expires on a tick that arrives while `phase_timer`==D-1. Each phase therefore lasts exactly D ticks.
- Transitions happen only on expiry:
  - MAIN_G → MAIN_Y, only if `side_req` or `ped_req` is set. Otherwise the FSM stays in MAIN_G and the timer holds at D-1.
  - MAIN_Y → RED_A.
  - RED_A → SIDE_G if `side_req` is set, else WALK_S.
  - SIDE_G → SIDE_Y → RED_B.
  - RED_B → WALK_S if `ped_req` is set, else MAIN_G.
  - WALK_S → MAIN_G.
- `side_req` latching:
  - Set on any cycle with `side_sensor`=1, except while in SIDE_G or SIDE_Y.
  - Cleared on the edge that enters SIDE_G. The clear wins over a simultaneous set.
- `ped_req` latching:
  - Set on any cycle with `ped_button`=1, except while in WALK_S.
  - Cleared on the edge that enters WALK_S. The clear wins.
- Light decode per state:
  - MAIN_G: main G, side R.
  - MAIN_Y: main Y, side R.
  - RED_A, RED_B, WALK_S: both heads R.
  - SIDE_G: side G, main R.
  - SIDE_Y: side Y, main R.
  - `walk`=1 only in WALK_S.
- Invariant: main and side are never both non-red. No head is ever all-zero or multi-hot.
- Reset value (asynchronous, while `global_reset`=0):
  - State MAIN_G, `phase_timer`=0, both requests cleared.
  - `main_light`=3'b001, `side_light`=3'b100, `walk`=0, `phase`=0.
- Reset asserted mid-phase aborts the phase immediately, with no yellow/red clearance. Release resumes at MAIN_G, timer 0.
- Ticks are ignored while reset is asserted.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- A tick arriving in cycle N takes effect at the edge that ends cycle N. The new state, timer and lights are visible in cycle N+1.
- A request that latches in cycle N can be acted on by an expiry tick in cycle N+1 or later. It cannot be acted on by a tick in cycle N itself.
- `enable_1Hz` held high for multiple cycles counts as one tick per cycle. The divider guarantees single-cycle pulses.
- Parameter value 0 is illegal. The design need not handle it.

## Configuration
- Macro: `TRAFFIC_PED_REQUEST_EN`.
- Defined: pedestrian logic present exactly as described above.
- Undefined:
  - `ped_button` is ignored, `ped_req` is constant 0, and WALK_S is unreachable.
  - RED_A always goes to SIDE_G.
  - RED_B always goes to MAIN_G.
  - `walk` is tied to 0.
  - MAIN_G exits only on `side_req`.

## Test plan
- Reset, then 10 ticks with no requests → stays in MAIN_G with `phase_timer` saturated at 3. Lights stay main=001, side=100.
- Pulse `side_sensor` 1 cycle, then tick continuously → phase sequence 0(4 ticks),1(2),2(1),3(3),4(2),5(1),0. `side_req` is cleared on entering SIDE_G.
- Pulse `ped_button` only (macro defined) → sequence 0,1,2,6(2 ticks, `walk`=1),0. With the macro undefined, the FSM stays in MAIN_G.
- Hold `side_sensor`=1 throughout → SIDE_G is re-served after every MAIN_G minimum. No request is latched during SIDE_G or SIDE_Y.
- Assert `global_reset`=0 mid-SIDE_G → outputs go to reset values asynchronously, before the next clk edge. After release, the FSM is in MAIN_G with timer 0.
- Check every cycle of all runs: never both heads non-red, and each head is one-hot.
